// File: rtl/d_cache_assoc.sv
// d_cache_assoc
//   N-way set-associative, write-back, write-allocate data cache with tree
//   pseudo-LRU replacement, configurable line length and per-byte write enables.
//   Sits between the CPU MEM stage and the shared memory arbiter.
//
// Ports
//   i_Clk, i_Reset             clock, synchronous active-high reset
//   i_Valid/i_Address/i_Read_Write_n/i_Byte_En/i_Write_Data
//                              CPU request (sampled while o_Ready=1)
//   o_Ready, o_Valid, o_Data   accept strobe, completion pulse, read data
//   o_MEM_Valid/o_MEM_Read_Write_n/o_MEM_Address/o_MEM_Data
//                              memory burst request (fill or writeback)
//   i_MEM_Valid/i_MEM_Data_Read/i_MEM_Last/i_MEM_Data
//                              memory burst handshake and fill data
//
// Optional feature: define D_CACHE_STATS_EN to add o_Hit_Count, o_Miss_Count
// and o_Writeback_Count (32-bit saturating counters cleared by i_Reset).
module d_cache_assoc #(
    parameter int DATA_WIDTH         = 32,
    parameter int TAG_WIDTH          = 11,
    parameter int INDEX_WIDTH        = 8,
    parameter int BLOCK_OFFSET_WIDTH = 2,
    parameter int NUM_WAYS           = 2,
    parameter int ADDRESS_WIDTH      = TAG_WIDTH + INDEX_WIDTH + BLOCK_OFFSET_WIDTH
) (
    input  logic                       i_Clk,
    input  logic                       i_Reset,
    input  logic                       i_Valid,
    input  logic [ADDRESS_WIDTH-1:0]   i_Address,
    input  logic                       i_Read_Write_n,
    input  logic [DATA_WIDTH/8-1:0]    i_Byte_En,
    input  logic [DATA_WIDTH-1:0]      i_Write_Data,
    output logic                       o_Ready,
    output logic                       o_Valid,
    output logic [DATA_WIDTH-1:0]      o_Data,
    output logic                       o_MEM_Valid,
    output logic                       o_MEM_Read_Write_n,
    output logic [ADDRESS_WIDTH:0]     o_MEM_Address,
    output logic [DATA_WIDTH-1:0]      o_MEM_Data,
    input  logic                       i_MEM_Valid,
    input  logic                       i_MEM_Data_Read,
    input  logic                       i_MEM_Last,
    input  logic [DATA_WIDTH-1:0]      i_MEM_Data
`ifdef D_CACHE_STATS_EN
    ,
    output logic [31:0]                o_Hit_Count,
    output logic [31:0]                o_Miss_Count,
    output logic [31:0]                o_Writeback_Count
`endif
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int SETS  = 1 << INDEX_WIDTH;
    localparam int WORDS = 1 << BLOCK_OFFSET_WIDTH;
    localparam int LOG2N = $clog2(NUM_WAYS);
    localparam int WAY_W = (LOG2N > 0) ? LOG2N : 1;
    localparam int PW    = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

    typedef enum logic [2:0] {S_READY, S_WRITEOUT, S_TURN, S_POPULATE, S_RESPOND} state_t;
    state_t state, next_state;

    // Tag array is read combinationally so all ways compare in the accept cycle;
    // data banks are read synchronously.
    logic [TAG_WIDTH-1:0]  tag_mem  [NUM_WAYS][SETS];
    logic [DATA_WIDTH-1:0] data_mem [NUM_WAYS][WORDS][SETS];
    logic [NUM_WAYS-1:0]   valid_q  [SETS];
    logic [NUM_WAYS-1:0]   dirty_q  [SETS];
    logic [PW-1:0]         plru_q   [SETS];

    logic [TAG_WIDTH-1:0]          in_tag, req_tag, vic_tag_q;
    logic [INDEX_WIDTH-1:0]        in_idx, req_idx;
    logic [BLOCK_OFFSET_WIDTH-1:0] in_off, req_off, wb_cnt, wb_next, fill_cnt;
    logic                          req_write, hit, have_inv, vic_dirty, accept, hit_vld;
    logic [NB-1:0]                 req_be;
    logic [DATA_WIDTH-1:0]         req_wdata, wb_data, fill_word;
    logic [WAY_W-1:0]              hit_way, inv_way, vic_way, vic_q;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_w,
                                                          input logic [DATA_WIDTH-1:0] new_w,
                                                          input logic [NB-1:0] be);
        logic [DATA_WIDTH-1:0] r;
        r = old_w;
        for (int b = 0; b < NB; b++)
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // Tree PLRU: node n (1-based heap order) is stored at bit n-1; a bit of 1
    // sends the victim search to the right child.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PW-1:0] bits);
        int node;
        node = 1;
        for (int l = 0; l < LOG2N; l++)
            node = 2 * node + int'(bits[node-1]);
        return WAY_W'(node - NUM_WAYS);
    endfunction

    // Point every node on the path to 'way' toward the opposite subtree.
    function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] bits,
                                                 input logic [WAY_W-1:0] way);
        logic [PW-1:0] r;
        int node, dir;
        r = bits;
        node = 1;
        for (int l = 0; l < LOG2N; l++) begin
            dir = (int'(way) >> (LOG2N - 1 - l)) & 1;
            r[node-1] = (dir == 0);
            node = 2 * node + dir;
        end
        return r;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    assign in_tag  = i_Address[ADDRESS_WIDTH-1 -: TAG_WIDTH];
    assign in_idx  = i_Address[BLOCK_OFFSET_WIDTH +: INDEX_WIDTH];
    assign in_off  = i_Address[BLOCK_OFFSET_WIDTH-1:0];
    assign accept  = (state == S_READY) && i_Valid && !i_Reset;
    assign wb_next = wb_cnt + BLOCK_OFFSET_WIDTH'(1);
    assign fill_word = (req_write && fill_cnt == req_off)
                       ? merge_bytes(i_MEM_Data, req_wdata, req_be) : i_MEM_Data;
    assign o_Valid = hit_vld || (state == S_RESPOND);

    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        have_inv = 1'b0;
        inv_way  = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!hit && valid_q[in_idx][w] && tag_mem[w][in_idx] == in_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!have_inv && !valid_q[in_idx][w]) begin
                have_inv = 1'b1;
                inv_way  = WAY_W'(w);
            end
        end
        vic_way   = have_inv ? inv_way : plru_victim(plru_q[in_idx]);
        vic_dirty = valid_q[in_idx][vic_way] && dirty_q[in_idx][vic_way];
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) state <= S_READY;
        else         state <= next_state;
    end

    always_comb begin
        next_state         = state;
        o_Ready            = 1'b0;
        o_MEM_Valid        = 1'b0;
        o_MEM_Read_Write_n = 1'b1;
        o_MEM_Address      = '0;
        o_MEM_Data         = '0;
        case (state)
            S_READY: begin
                o_Ready = !i_Reset;
                if (accept && !hit)
                    next_state = vic_dirty ? S_WRITEOUT : S_POPULATE;
            end
            S_WRITEOUT: begin
                o_MEM_Valid        = 1'b1;
                o_MEM_Read_Write_n = 1'b0;
                o_MEM_Address      = {vic_tag_q, req_idx, {(BLOCK_OFFSET_WIDTH+1){1'b0}}};
                o_MEM_Data         = wb_data;
                if (i_MEM_Data_Read && i_MEM_Last) next_state = S_TURN;
            end
            S_TURN: next_state = S_POPULATE;
            S_POPULATE: begin
                o_MEM_Valid   = 1'b1;
                o_MEM_Address = {req_tag, req_idx, {(BLOCK_OFFSET_WIDTH+1){1'b0}}};
                if (i_MEM_Valid && i_MEM_Last) next_state = S_RESPOND;
            end
            S_RESPOND: next_state = S_READY;
            default:   next_state = S_READY;
        endcase
    end

    // Control state: valid/dirty/PLRU, completion pulse, returned word, counters.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
            hit_vld <= 1'b0;
            o_Data  <= '0;
`ifdef D_CACHE_STATS_EN
            o_Hit_Count       <= '0;
            o_Miss_Count      <= '0;
            o_Writeback_Count <= '0;
`endif
        end else begin
            hit_vld <= accept && hit;
            if (accept && hit) begin
                plru_q[in_idx] <= plru_touch(plru_q[in_idx], hit_way);
                if (i_Read_Write_n) begin
                    o_Data <= data_mem[hit_way][in_off][in_idx];
                end else begin
                    dirty_q[in_idx][hit_way] <= 1'b1;
                    o_Data <= merge_bytes(data_mem[hit_way][in_off][in_idx], i_Write_Data, i_Byte_En);
                end
            end
            if (state == S_WRITEOUT && i_MEM_Data_Read && i_MEM_Last)
                dirty_q[req_idx][vic_q] <= 1'b0;
            if (state == S_POPULATE && i_MEM_Valid) begin
                if (fill_cnt == req_off) o_Data <= fill_word;
                if (i_MEM_Last) begin
                    valid_q[req_idx][vic_q] <= 1'b1;
                    dirty_q[req_idx][vic_q] <= req_write;
                    plru_q[req_idx]         <= plru_touch(plru_q[req_idx], vic_q);
                end
            end
`ifdef D_CACHE_STATS_EN
            if (accept && hit)  o_Hit_Count  <= sat_inc(o_Hit_Count);
            if (accept && !hit) o_Miss_Count <= sat_inc(o_Miss_Count);
            if (accept && !hit && vic_dirty) o_Writeback_Count <= sat_inc(o_Writeback_Count);
`endif
        end
    end

    // Datapath: request latch, tag/data RAM writes, writeback word prefetch.
    always_ff @(posedge i_Clk) begin
        if (accept) begin
            req_tag   <= in_tag;
            req_idx   <= in_idx;
            req_off   <= in_off;
            req_write <= !i_Read_Write_n;
            req_be    <= i_Byte_En;
            req_wdata <= i_Write_Data;
            vic_q     <= vic_way;
            vic_tag_q <= tag_mem[vic_way][in_idx];
            wb_cnt    <= '0;
            fill_cnt  <= '0;
            // Word 0 of the victim is fetched now so it is on o_MEM_Data in the
            // first WRITEOUT cycle.
            wb_data   <= data_mem[vic_way][0][in_idx];
            if (hit && !i_Read_Write_n)
                for (int b = 0; b < NB; b++)
                    if (i_Byte_En[b])
                        data_mem[hit_way][in_off][in_idx][8*b +: 8] <= i_Write_Data[8*b +: 8];
        end
        if (state == S_WRITEOUT && i_MEM_Data_Read) begin
            wb_cnt  <= wb_next;
            wb_data <= data_mem[vic_q][wb_next][req_idx];
        end
        if (state == S_POPULATE && i_MEM_Valid && !i_Reset) begin
            data_mem[vic_q][fill_cnt][req_idx] <= fill_word;
            fill_cnt <= fill_cnt + BLOCK_OFFSET_WIDTH'(1);
            if (i_MEM_Last) tag_mem[vic_q][req_idx] <= req_tag;
        end
    end

endmodule

// File: tb/tb_d_cache_assoc.sv
// tb_d_cache_assoc
//   Directed bench for d_cache_assoc (default 2-way build). Holds a flat
//   "latest value per address" view of memory, a backing store served over the
//   burst protocol, and a per-set tag/valid/dirty/MRU model of the cache.
`timescale 1ns/1ps
module tb_d_cache_assoc;
    localparam int DW = 32, TW = 11, IW = 8, BOW = 2, NW = 2, AW = 21;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, valid, rw_n, rdy, ovalid, mvalid, mrw_n;
    logic          mem_valid, mem_read, mem_last;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   wdata, odata, mdata, mem_data;
    logic [AW:0]   maddr;

    d_cache_assoc #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .INDEX_WIDTH(IW),
                    .BLOCK_OFFSET_WIDTH(BOW), .NUM_WAYS(NW)) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Valid(valid), .i_Address(addr),
        .i_Read_Write_n(rw_n), .i_Byte_En(be), .i_Write_Data(wdata),
        .o_Ready(rdy), .o_Valid(ovalid), .o_Data(odata),
        .o_MEM_Valid(mvalid), .o_MEM_Read_Write_n(mrw_n), .o_MEM_Address(maddr),
        .o_MEM_Data(mdata), .i_MEM_Valid(mem_valid), .i_MEM_Data_Read(mem_read),
        .i_MEM_Last(mem_last), .i_MEM_Data(mem_data));

    int vectors = 0, miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory views: bmem = what the memory side holds, ref_mem = latest write.
    logic [31:0] bmem [int];
    logic [31:0] ref_mem [int];

    function automatic logic [31:0] bval(input int a);
        return bmem.exists(a) ? bmem[a] : 32'(a + 32'h90);
    endfunction
    function automatic logic [31:0] ref_val(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : bval(a);
    endfunction
    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] e);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = e[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    // Cache model: per set, two ways with tag/valid/dirty and the most recently used way.
    bit mv [256][2];
    bit md [256][2];
    int mt [256][2];
    int mmru [256];

    task automatic model_reset();
        for (int s = 0; s < 256; s++) begin
            mmru[s] = 0;
            for (int w = 0; w < 2; w++) begin mv[s][w] = 0; md[s][w] = 0; end
        end
    endtask

    task automatic predict(input int a, input bit is_wr, output bit eh, output bit ewb,
                           output int ewba, output int efa);
        int idx, tag, hw, v;
        idx = (a >> 2) & 255;
        tag = a >> 10;
        hw = -1;
        ewb = 0; ewba = 0; efa = 0;
        for (int w = 0; w < 2; w++) if (mv[idx][w] && mt[idx][w] == tag) hw = w;
        eh = (hw >= 0);
        if (eh) begin
            mmru[idx] = hw;
            if (is_wr) md[idx][hw] = 1;
        end else begin
            v = !mv[idx][0] ? 0 : (!mv[idx][1] ? 1 : 1 - mmru[idx]);
            ewb  = mv[idx][v] && md[idx][v];
            ewba = ((mt[idx][v] << 8) | idx) << 3;
            efa  = (a & ~3) << 1;
            mv[idx][v] = 1; mt[idx][v] = tag; md[idx][v] = is_wr; mmru[idx] = v;
        end
    endtask

    typedef struct { bit rd; logic [31:0] d; } exp_t;
    exp_t exp_q[$];

    // Every completion pulse is matched against the next expected response.
    always @(negedge clk) begin
        exp_t e;
        if (ovalid === 1'b1) begin
            if (exp_q.size() == 0) chk("valid_without_request", ovalid, 1'b0);
            else begin
                e = exp_q.pop_front();
                if (e.rd) chk("read_data", odata, e.d);
            end
        end
    end

    // Issue one request from a negedge, serve any bursts, return at the o_Valid negedge.
    task automatic access(input int a, input bit rd, input logic [3:0] e, input logic [31:0] wd,
                          output logic [31:0] got, output logic [31:0] wba, output logic [31:0] fa,
                          output logic [3:0][31:0] ww, output int lat);
        bit eh, ewb, prev_last;
        int ewba, efa, kw, kf, n, base;
        exp_t x;
        predict(a, !rd, eh, ewb, ewba, efa);
        x.rd = rd;
        if (rd) x.d = ref_val(a);
        else begin ref_mem[a] = merge(ref_val(a), wd, e); x.d = ref_mem[a]; end
        exp_q.push_back(x);
        n = 0;
        while (rdy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (n == 20) chk("ready_timeout", rdy, 1'b1);
        valid = 1; addr = AW'(a); rw_n = rd; be = e; wdata = wd;
        @(posedge clk); @(negedge clk);
        valid = 0;
        wba = '1; fa = '1; ww = '0; kw = 0; kf = 0; lat = 0; prev_last = 0;
        while (lat < 200) begin
            mem_read = 0; mem_valid = 0; mem_last = 0;
            if (prev_last) chk("turn_gap", mvalid, 1'b0);
            prev_last = 0;
            if (ovalid === 1'b1) break;
            base = int'(maddr >> 1);
            if (mvalid === 1'b1 && mrw_n === 1'b0 && kw < 4) begin
                if (kw == 0) wba = 32'(maddr);
                chk("wb_word", mdata, ref_val(base + kw));
                ww[kw] = mdata;
                bmem[base + kw] = mdata;
                mem_read = 1; mem_last = (kw == 3); prev_last = (kw == 3);
                kw++;
            end else if (mvalid === 1'b1 && mrw_n === 1'b1 && kf < 4) begin
                if (kf == 0) fa = 32'(maddr);
                mem_valid = 1; mem_data = bval(base + kf); mem_last = (kf == 3);
                kf++;
            end
            @(posedge clk); @(negedge clk);
            lat++;
        end
        mem_read = 0; mem_valid = 0; mem_last = 0;
        got = odata;
        chk("completed", lat < 200, 1'b1);
        chk("fill_words", kf, eh ? 0 : 4);
        chk("wb_words", kw, ewb ? 4 : 0);
        if (eh) begin
            chk("hit_latency", lat, 0);
            chk("ready_after_hit", rdy, 1'b1);
        end else begin
            chk("fill_addr", fa, efa);
            chk("ready_in_respond", rdy, 1'b0);
            if (ewb) chk("wb_addr", wba, ewba);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] got, wba, fa;
        logic [3:0][31:0] ww;
        int lat;
        rst = 1; valid = 0; addr = '0; rw_n = 1; be = '0; wdata = '0;
        mem_valid = 0; mem_read = 0; mem_last = 0; mem_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", rdy, 1'b0);
        chk("rst_valid", ovalid, 1'b0);
        chk("rst_mem_valid", mvalid, 1'b0);
        chk("rst_mem_rw", mrw_n, 1'b1);
        chk("rst_mem_addr", maddr, 0);
        chk("rst_mem_data", mdata, 0);
        chk("rst_data", odata, 0);
        rst = 0;
        model_reset();
        @(negedge clk);

        // 1: cold read miss, line fill from 0x20
        access(32'h10, 1, 4'h0, 0, got, wba, fa, ww, lat);
        chk("t1_fill_addr", fa, 32'h20);
        chk("t1_data", got, 32'hA0);
        // 2: hit on the same line
        access(32'h11, 1, 4'h0, 0, got, wba, fa, ww, lat);
        chk("t2_data", got, 32'hA1);
        chk("t2_latency", lat, 0);
        // 3: full write, then low-half byte write, then reread
        access(32'h11, 0, 4'hF, 32'h12345678, got, wba, fa, ww, lat);
        access(32'h11, 0, 4'b0011, 32'hFFFFFFFF, got, wba, fa, ww, lat);
        access(32'h11, 1, 4'h0, 0, got, wba, fa, ww, lat);
        chk("t3_data", got, 32'h1234FFFF);
        access(32'h12, 0, 4'b1000, 32'hAB000000, got, wba, fa, ww, lat);
        access(32'h12, 1, 4'h0, 0, got, wba, fa, ww, lat);
        chk("top_byte_data", got, 32'hAB0000A2);
        // 4: fill way1, then evict dirty way0
        access(32'h410, 1, 4'h0, 0, got, wba, fa, ww, lat);
        chk("t4_fill1_addr", fa, 32'h820);
        access(32'h810, 1, 4'h0, 0, got, wba, fa, ww, lat);
        chk("t4_wb_addr", wba, 32'h20);
        chk("t4_wb_word1", ww[1], 32'h1234FFFF);
        chk("t4_wb_word2", ww[2], 32'hAB0000A2);
        chk("t4_fill2_addr", fa, 32'h1020);
        chk("t4_data", got, 32'h8A0);
        // written-back line comes back from memory
        access(32'h10, 1, 4'h0, 0, got, wba, fa, ww, lat);
        access(32'h11, 1, 4'h0, 0, got, wba, fa, ww, lat);
        chk("refetch_data", got, 32'h1234FFFF);
        // 5: write miss allocates a dirty line
        access(32'h20, 0, 4'hF, 32'h55, got, wba, fa, ww, lat);
        chk("t5_fill_addr", fa, 32'h40);
        access(32'h21, 1, 4'h0, 0, got, wba, fa, ww, lat);
        access(32'h420, 1, 4'h0, 0, got, wba, fa, ww, lat);
        access(32'h820, 1, 4'h0, 0, got, wba, fa, ww, lat);
        chk("t5_wb_addr", wba, 32'h40);
        chk("t5_wb_word0", ww[0], 32'h55);
        // 6: reset in the middle of a fill
        while (rdy !== 1'b1) @(negedge clk);
        valid = 1; addr = AW'(32'hC30); rw_n = 1;
        @(posedge clk); @(negedge clk);
        valid = 0;
        for (int k = 0; k < 2; k++) begin
            chk("t6_mem_valid", mvalid, 1'b1);
            mem_valid = 1; mem_data = bval(32'hC30 + k); mem_last = 0;
            @(posedge clk); @(negedge clk);
        end
        mem_valid = 0;
        rst = 1;
        @(posedge clk); @(negedge clk);
        chk("t6_abort_mem_valid", mvalid, 1'b0);
        chk("t6_ready_in_reset", rdy, 1'b0);
        rst = 0;
        model_reset();
        ref_mem.delete();
        @(negedge clk);
        access(32'hC30, 1, 4'h0, 0, got, wba, fa, ww, lat);
        chk("t6_refill_addr", fa, 32'h1860);
        chk("t6_data", got, 32'hCC0);

        @(negedge clk);
        chk("responses_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
